// File: rtl/flow_ctrl.sv
// Pipeline flow scheduler: drives WORK/STOP/REFRESH codes into the PC and inter-stage registers,
// arbitrating traps, memory waits, taken jumps and load-use stalls.
module flow_ctrl #(
  parameter int                    FLOW_WIDTH   = 2,
  parameter logic [FLOW_WIDTH-1:0] FLOW_WORK    = 2'b00,
  parameter logic [FLOW_WIDTH-1:0] FLOW_STOP    = 2'b01,
  parameter logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'b10,
  parameter int                    LU_CYCLES    = 1,
  parameter int                    MEM_TIMEOUT  = 255,
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_use_i,
  input  logic                  jump_i,
  input  logic                  mem_busy_i,
  input  logic                  trap_i,
  output logic [FLOW_WIDTH-1:0] flow_pc_o,
  output logic [FLOW_WIDTH-1:0] flow_if_id_o,
  output logic [FLOW_WIDTH-1:0] flow_id_ex_o,
  output logic [FLOW_WIDTH-1:0] flow_ex_mem_o,
  output logic [FLOW_WIDTH-1:0] flow_mem_wb_o,
  output logic                  trap_ack_o,
  output logic                  mem_timeout_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam int VW   = 5 * FLOW_WIDTH;
  localparam int LU_W = (LU_CYCLES > 1) ? $clog2(LU_CYCLES) : 1;

  localparam logic [LU_W-1:0] LU_LAST = LU_W'(LU_CYCLES - 1);
  localparam logic [15:0]     TMO     = 16'(MEM_TIMEOUT);

  // Flow vectors ordered {pc, if_id, id_ex, ex_mem, mem_wb}
  localparam logic [VW-1:0] V_NORM  = {5{FLOW_WORK}};
  localparam logic [VW-1:0] V_RST   = {5{FLOW_REFRESH}};
  localparam logic [VW-1:0] V_MEMW  = {FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_REFRESH};
  localparam logic [VW-1:0] V_TRAPF = {FLOW_WORK, FLOW_REFRESH, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK};
  localparam logic [VW-1:0] V_JMP   = {FLOW_WORK, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK, FLOW_WORK};
  localparam logic [VW-1:0] V_LU    = {FLOW_STOP, FLOW_STOP, FLOW_REFRESH, FLOW_WORK, FLOW_WORK};

  localparam logic [1:0] S_RUN        = 2'd0;
  localparam logic [1:0] S_MEM_WAIT   = 2'd1;
  localparam logic [1:0] S_LU_STALL   = 2'd2;
  localparam logic [1:0] S_TRAP_DRAIN = 2'd3;

  logic [1:0]      state, state_nxt, run_state;
  logic [LU_W-1:0] lu_cnt, lu_nxt, run_lu;
  logic [15:0]     wait_cnt, wait_nxt, run_wait;
  logic [VW-1:0]   vec, run_vec;
  logic            ack, run_ack;

  // Plain RUN-state decision; the other states fall back to it in several cases.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    run_vec   = V_NORM;
    run_ack   = 1'b0;
    run_state = S_RUN;
    run_wait  = '0;
    run_lu    = '0;
    if (trap_i && !mem_busy_i) begin
      run_vec = V_TRAPF;
      run_ack = 1'b1;
    end else if (trap_i) begin
      run_vec   = V_MEMW;
      run_state = S_TRAP_DRAIN;
    end else if (mem_busy_i) begin
      run_vec   = V_MEMW;
      run_state = S_MEM_WAIT;
      run_wait  = 16'd1;
    end else if (jump_i) begin
      run_vec = V_JMP;
    end else if (ld_use_i) begin
      run_vec = V_LU;
      if (LU_CYCLES > 1) begin
        run_state = S_LU_STALL;
        run_lu    = LU_W'(1);
      end
    end
  end

  always_comb begin
    vec       = run_vec;
    ack       = run_ack;
    state_nxt = run_state;
    wait_nxt  = run_wait;
    lu_nxt    = run_lu;
    case (state)
      S_MEM_WAIT: begin
        if (mem_busy_i) begin
          vec       = V_MEMW;
          ack       = 1'b0;
          state_nxt = S_MEM_WAIT;
          lu_nxt    = '0;
          wait_nxt  = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
        end
      end
      S_LU_STALL: begin
        if (!trap_i && !mem_busy_i) begin
          ack       = 1'b0;
          lu_nxt    = '0;
          state_nxt = S_RUN;
          if (jump_i) begin
            vec = V_JMP;
          end else begin
            vec = V_LU;
            if (lu_cnt != LU_LAST) begin
              state_nxt = S_LU_STALL;
              lu_nxt    = lu_cnt + 1'b1;
            end
          end
        end
      end
      S_TRAP_DRAIN: begin
        // The flush completes even if trap_i dropped early.
        wait_nxt = '0;
        lu_nxt   = '0;
        if (mem_busy_i) begin
          vec       = V_MEMW;
          ack       = 1'b0;
          state_nxt = S_TRAP_DRAIN;
        end else begin
          vec       = V_TRAPF;
          ack       = 1'b1;
          state_nxt = S_RUN;
        end
      end
      default: ;
    endcase
    if (rst) begin
      vec = V_RST;
      ack = 1'b0;
    end
  end

  assign {flow_pc_o, flow_if_id_o, flow_id_ex_o, flow_ex_mem_o, flow_mem_wb_o} = vec;
  assign trap_ack_o = ack;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_RUN;
      lu_cnt        <= '0;
      wait_cnt      <= '0;
      mem_timeout_o <= 1'b0;
      stall_cnt_o   <= '0;
    end else begin
      state    <= state_nxt;
      lu_cnt   <= lu_nxt;
      wait_cnt <= wait_nxt;
      if (wait_nxt == TMO)
        mem_timeout_o <= 1'b1;
      if (flow_pc_o != FLOW_WORK && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_flow_ctrl.sv
// Bench for flow_ctrl: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a behavioural model of the scheduling rules.
module tb_flow_ctrl;

  localparam int LU_CYCLES   = 2;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_WIDTH   = 6;
  localparam int STALL_MAX   = (1 << CNT_WIDTH) - 1;

  localparam logic [9:0] E_NORM  = 10'b00_00_00_00_00;
  localparam logic [9:0] E_RST   = 10'b10_10_10_10_10;
  localparam logic [9:0] E_MEMW  = 10'b01_01_01_01_10;
  localparam logic [9:0] E_TRAPF = 10'b00_10_10_10_00;
  localparam logic [9:0] E_JMP   = 10'b00_10_10_00_00;
  localparam logic [9:0] E_LU    = 10'b01_01_10_00_00;

  logic clk = 1'b0;
  logic rst = 1'b1, ld_use = 1'b0, jump = 1'b0, mem_busy = 1'b0, trap = 1'b0;
  logic [1:0] f_pc, f_if_id, f_id_ex, f_ex_mem, f_mem_wb;
  logic trap_ack, mem_timeout;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [9:0] dut_vec;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flow_ctrl #(
    .FLOW_WIDTH(2), .FLOW_WORK(2'b00), .FLOW_STOP(2'b01), .FLOW_REFRESH(2'b10),
    .LU_CYCLES(LU_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .ld_use_i(ld_use), .jump_i(jump), .mem_busy_i(mem_busy), .trap_i(trap),
    .flow_pc_o(f_pc), .flow_if_id_o(f_if_id), .flow_id_ex_o(f_id_ex),
    .flow_ex_mem_o(f_ex_mem), .flow_mem_wb_o(f_mem_wb),
    .trap_ack_o(trap_ack), .mem_timeout_o(mem_timeout), .stall_cnt_o(stall_cnt)
  );

  assign dut_vec = {f_pc, f_if_id, f_id_ex, f_ex_mem, f_mem_wb};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: mode of the pipeline plus remaining-stall and busy-cycle counts.
  typedef enum int {M_RUN, M_MEMW, M_LU, M_DRAIN} mode_t;
  mode_t m_mode = M_RUN;
  int    m_lu_left = 0;
  int    m_waits = 0;
  bit    m_tmo = 1'b0;
  int    m_stall = 0;
  bit    armed = 1'b0;
  logic [9:0] m_ev;
  bit    m_ea;

  task automatic model_step(input bit r, t, b, j, l, output logic [9:0] ev, output bit ea);
    ea = 1'b0;
    ev = E_NORM;
    if (r) begin
      ev = E_RST;
      m_mode = M_RUN; m_lu_left = 0; m_waits = 0; m_tmo = 1'b0; m_stall = 0;
      return;
    end
    if (m_mode == M_DRAIN) begin
      if (b) ev = E_MEMW;
      else begin ev = E_TRAPF; ea = 1'b1; m_mode = M_RUN; end
    end else if (m_mode == M_MEMW && b) begin
      ev = E_MEMW;
      if (m_waits < 65535) m_waits++;
    end else if (m_mode == M_LU && !t && !b) begin
      if (j) begin ev = E_JMP; m_mode = M_RUN; end
      else begin
        ev = E_LU;
        m_lu_left--;
        if (m_lu_left == 0) m_mode = M_RUN;
      end
    end else begin
      m_waits = 0;
      m_mode  = M_RUN;
      if (t && !b) begin ev = E_TRAPF; ea = 1'b1; end
      else if (t) begin ev = E_MEMW; m_mode = M_DRAIN; end
      else if (b) begin ev = E_MEMW; m_mode = M_MEMW; m_waits = 1; end
      else if (j) ev = E_JMP;
      else if (l) begin
        ev = E_LU;
        m_lu_left = LU_CYCLES - 1;
        if (m_lu_left > 0) m_mode = M_LU;
      end
    end
    if (m_waits == MEM_TIMEOUT) m_tmo = 1'b1;
    if (ev[9:8] != 2'b00 && m_stall < STALL_MAX) m_stall++;
  endtask

  // Registered outputs are compared before the model advances; flows and ack after.
  always @(negedge clk) begin
    if (armed) begin
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
    end
    if (armed || rst) begin
      model_step(rst, trap, mem_busy, jump, ld_use, m_ev, m_ea);
      check("flows", 32'(dut_vec), 32'(m_ev));
      check("trap_ack", 32'(trap_ack), 32'(m_ea));
      if (rst) armed = 1'b1;
    end
  end

  task automatic cyc(input bit r, t, b, j, l);
    @(posedge clk);
    #1;
    rst = r; trap = t; mem_busy = b; jump = j; ld_use = l;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ack_seen;
    int burst;

    // Reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_flows", 32'(dut_vec), 32'(E_RST));
    check("rst_ack", 32'(trap_ack), 32'd0);

    // Idle
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
    check("idle_flows", 32'(dut_vec), 32'(E_NORM));
    check("idle_stall", 32'(stall_cnt), 32'd0);

    // Load-use pulse: two stall cycles
    cyc(0, 0, 0, 0, 1);
    check("lu_1", 32'(dut_vec), 32'(E_LU));
    cyc(0, 0, 0, 0, 0);
    check("lu_2", 32'(dut_vec), 32'(E_LU));
    cyc(0, 0, 0, 0, 0);
    check("lu_done", 32'(dut_vec), 32'(E_NORM));
    check("lu_stall", 32'(stall_cnt), 32'd2);

    // Jump beats load-use, no stall follows
    cyc(0, 0, 0, 1, 1);
    check("jmp_lu", 32'(dut_vec), 32'(E_JMP));
    cyc(0, 0, 0, 0, 0);
    check("jmp_after", 32'(dut_vec), 32'(E_NORM));
    check("jmp_stall", 32'(stall_cnt), 32'd2);

    // Memory wait with jump held, jump taken on release
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 0);
      check("memw_jmp", 32'(dut_vec), 32'(E_MEMW));
    end
    cyc(0, 0, 0, 1, 0);
    check("memw_release", 32'(dut_vec), 32'(E_JMP));
    cyc(0, 0, 0, 0, 0);
    check("memw_stall", 32'(stall_cnt), 32'd5);
    check("memw_no_tmo", 32'(mem_timeout), 32'd0);

    // Timeout after 4 busy cycles, sticky until reset
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 0, 1, 0, 0);
      if (i == 3) check("tmo_before", 32'(mem_timeout), 32'd0);
      if (i == 5) check("tmo_set", 32'(mem_timeout), 32'd1);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("tmo_sticky", 32'(mem_timeout), 32'd1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("tmo_clear", 32'(mem_timeout), 32'd0);

    // Trap during memory wait
    cyc(0, 1, 1, 0, 0);
    check("drain_1", 32'(dut_vec), 32'(E_MEMW));
    cyc(0, 1, 1, 0, 0);
    check("drain_2", 32'(dut_vec), 32'(E_MEMW));
    cyc(0, 1, 0, 0, 0);
    check("trap_flush", 32'(dut_vec), 32'(E_TRAPF));
    check("trap_ack_hi", 32'(trap_ack), 32'd1);
    cyc(0, 0, 0, 0, 0);
    check("trap_ack_lo", 32'(trap_ack), 32'd0);

    // Reset in the middle of a drain
    cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    check("drain_rst", 32'(dut_vec), 32'(E_RST));
    cyc(0, 0, 0, 0, 0);
    check("drain_rst_run", 32'(dut_vec), 32'(E_NORM));

    // Randomized traffic; trap is held until acknowledged
    ack_seen = 1'b0;
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, t, b, j, l;
      r = ($urandom % 200) == 0;
      t = trap;
      if (r || ack_seen) t = 1'b0;
      else if (!t) t = ($urandom % 25) == 0;
      if (burst > 0) begin
        b = 1'b1;
        burst--;
      end else if (($urandom % 40) == 0) begin
        b = 1'b1;
        burst = $urandom_range(2, 7);
      end else begin
        b = ($urandom % 6) == 0;
      end
      j = ($urandom % 6) == 0;
      l = ($urandom % 4) == 0;
      cyc(r, t, b, j, l);
      ack_seen = trap_ack;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
